// File: rtl/dac_spi_tx.sv
// SPI transmitter for a dual-channel 12-bit DAC: sends one or two 16-bit frames
// (channel A first), then pulses ldac_n to latch both outputs together.
module dac_spi_tx #(
  parameter int unsigned CLK_DIV  = 2,
  parameter int unsigned CS_GAP   = 4,
  parameter int unsigned LDAC_W   = 2,
  parameter logic [3:0]  CFG_BITS = 4'b0011
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_clk_sampling,
  input  logic        i_enableA,
  input  logic        i_enableB,
  input  logic [11:0] i_dacA_word,
  input  logic [11:0] i_dacB_word,
  output logic        o_cs_n,
  output logic        o_sck,
  output logic        o_sdi,
  output logic        o_ldac_n,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_overrun
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;
  localparam logic [1:0] S_LDAC  = 2'd3;

  localparam logic [7:0] DIV_LAST  = 8'(CLK_DIV - 1);
  localparam logic [7:0] GAP_LAST  = 8'(CS_GAP - 1);
  localparam logic [7:0] LDAC_LAST = 8'(LDAC_W - 1);

  logic [1:0]  r_state;
  logic        r_cs_n;
  logic        r_sck;
  logic        r_sdi;
  logic        r_ldac_n;
  logic        r_done;
  logic        r_overrun;
  logic [15:0] r_shift;
  logic [7:0]  r_divCnt;
  logic [4:0]  r_halfCnt;
  logic [7:0]  r_gapCnt;
  logic [7:0]  r_ldacCnt;
  logic [11:0] r_wordB;
  logic        r_pendB;

  logic [15:0] w_frameA;
  logic [15:0] w_frameBIn;
  logic [15:0] w_frameBLat;
  logic        w_accept;
  logic        w_divTick;

  assign w_frameA    = {1'b0, CFG_BITS[2:0], i_dacA_word};
  assign w_frameBIn  = {1'b1, CFG_BITS[2:0], i_dacB_word};
  assign w_frameBLat = {1'b1, CFG_BITS[2:0], r_wordB};
  assign w_accept    = (r_state == S_IDLE) && i_clk_sampling && (i_enableA || i_enableB);
  assign w_divTick   = (r_divCnt == DIV_LAST);

  // r_halfCnt counts sck half-periods; the 32nd ends the frame on a falling edge
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_cs_n    <= 1'b1;
      r_sck     <= 1'b0;
      r_sdi     <= 1'b0;
      r_ldac_n  <= 1'b1;
      r_done    <= 1'b0;
      r_overrun <= 1'b0;
      r_shift   <= 16'd0;
      r_divCnt  <= 8'd0;
      r_halfCnt <= 5'd0;
      r_gapCnt  <= 8'd0;
      r_ldacCnt <= 8'd0;
      r_wordB   <= 12'd0;
      r_pendB   <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_overrun <= i_clk_sampling && (r_state != S_IDLE);
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_state   <= S_SHIFT;
            r_cs_n    <= 1'b0;
            r_sck     <= 1'b0;
            r_divCnt  <= 8'd0;
            r_halfCnt <= 5'd0;
            r_wordB   <= i_dacB_word;
            r_pendB   <= i_enableA && i_enableB;
            if (i_enableA) begin
              r_shift <= w_frameA;
              r_sdi   <= w_frameA[15];
            end else begin
              r_shift <= w_frameBIn;
              r_sdi   <= w_frameBIn[15];
            end
          end
        end
        S_SHIFT: begin
          if (w_divTick) begin
            r_divCnt  <= 8'd0;
            r_halfCnt <= r_halfCnt + 5'd1;
            if (!r_sck) begin
              r_sck <= 1'b1;
            end else if (r_halfCnt == 5'd31) begin
              r_state  <= S_GAP;
              r_sck    <= 1'b0;
              r_cs_n   <= 1'b1;
              r_sdi    <= 1'b0;
              r_gapCnt <= 8'd0;
            end else begin
              r_sck   <= 1'b0;
              r_shift <= {r_shift[14:0], 1'b0};
              r_sdi   <= r_shift[14];
            end
          end else begin
            r_divCnt <= r_divCnt + 8'd1;
          end
        end
        S_GAP: begin
          if (r_gapCnt == GAP_LAST) begin
            if (r_pendB) begin
              r_pendB   <= 1'b0;
              r_state   <= S_SHIFT;
              r_cs_n    <= 1'b0;
              r_sck     <= 1'b0;
              r_divCnt  <= 8'd0;
              r_halfCnt <= 5'd0;
              r_shift   <= w_frameBLat;
              r_sdi     <= w_frameBLat[15];
            end else begin
              r_state   <= S_LDAC;
              r_ldac_n  <= 1'b0;
              r_ldacCnt <= 8'd0;
            end
          end else begin
            r_gapCnt <= r_gapCnt + 8'd1;
          end
        end
        S_LDAC: begin
          if (r_ldacCnt == LDAC_LAST) begin
            r_state  <= S_IDLE;
            r_ldac_n <= 1'b1;
            r_done   <= 1'b1;
          end else begin
            r_ldacCnt <= r_ldacCnt + 8'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_cs_n    = r_cs_n;
  assign o_sck     = r_sck;
  assign o_sdi     = r_sdi;
  assign o_ldac_n  = r_ldac_n;
  assign o_busy    = (r_state != S_IDLE);
  assign o_done    = r_done;
  assign o_overrun = r_overrun;

endmodule

// File: doc/dac_spi_tx.md
DAC_SPI_TX -- requirements
Module: dac_spi_tx

Interface
REQ-001 Parameter CLK_DIV, default 2: SCK half-period in clk cycles, legal 1..255.
REQ-002 Parameter CS_GAP, default 4: cs_n high cycles after each frame, legal 1..255.
REQ-003 Parameter LDAC_W, default 2: ldac_n low cycles per transaction, legal 1..255.
REQ-004 Parameter CFG_BITS, default 4'b0011: frame bits [14:12] = {BUF, GA_n, SHDN_n} from CFG_BITS[2:0]; CFG_BITS[3] is unused.
REQ-005 clk  input  1  system clock; all logic on its rising edge.
REQ-006 rst_n  input  1  reset; synchronous, active-low.
REQ-007 clk_sampling  input  1  one-cycle sample-strobe pulse (50 kHz).
REQ-008 enableA / enableB  input  1 each  channel transmit enables, sampled with the strobe.
REQ-009 dacA_word / dacB_word  input  12 each  unsigned DAC codes, sampled with the strobe.
REQ-010 cs_n  output  1  DAC chip select, active-low.
REQ-011 sck  output  1  SPI clock, mode 0, idles low.
REQ-012 sdi  output  1  SPI data, MSB first.
REQ-013 ldac_n  output  1  DAC latch strobe, active-low.
REQ-014 busy  output  1  high whenever state is not IDLE.
REQ-015 done  output  1  one-cycle pulse at transaction end.
REQ-016 overrun  output  1  one-cycle pulse when a strobe is dropped.

Function
REQ-017 The FSM SHALL have states IDLE, SHIFT, GAP, LDAC.
REQ-018 Accept rule: in IDLE, clk_sampling=1 with (enableA|enableB)=1 SHALL latch both words and enables and enter SHIFT next cycle.
REQ-019 A strobe in IDLE with both enables 0 SHALL be ignored: no outputs change and no done.
REQ-020 Frame word SHALL be {ch, CFG_BITS[2:0], word[11:0]}: ch=0 for A, ch=1 for B.
REQ-021 Channel A SHALL be sent first when enabled; channel B follows when enabled.
REQ-022 On SHIFT entry, cs_n SHALL go 0 and sdi SHALL present frame bit 15 in the same cycle, with sck=0.
REQ-023 sck SHALL toggle every CLK_DIV cycles. sdi SHALL change only after sck falls; no shift after the final falling edge.
REQ-024 Each frame SHALL contain exactly 16 sck rising edges. cs_n SHALL be low for exactly 32*CLK_DIV cycles.
REQ-025 After the 16th sck falling edge: cs_n=1, sck=0, and GAP holds for CS_GAP cycles.
REQ-026 GAP exit SHALL go to SHIFT for channel B if it is pending, else to LDAC.
REQ-027 In LDAC, ldac_n SHALL be 0 for exactly LDAC_W cycles with cs_n=1; LDAC SHALL then go to IDLE.
REQ-028 done SHALL be 1 in the first IDLE cycle after LDAC. A strobe in that same cycle SHALL be accepted.
REQ-029 A strobe while busy=1 SHALL be dropped, overrun SHALL pulse the next cycle, and the transfer in progress SHALL be unaffected.
REQ-030 Changes to dacA_word, dacB_word or the enables during a transaction SHALL NOT affect it.
REQ-031 sdi SHALL be 0 whenever cs_n=1.

Reset
REQ-032 On a clk edge with rst_n=0, the block SHALL set: state IDLE, cs_n=1, sck=0, sdi=0, ldac_n=1, busy=0, done=0, overrun=0, all counters and latches 0.
REQ-033 Reset mid-frame or mid-LDAC SHALL abort immediately with no further sck edges and no ldac_n pulse.

Verification
REQ-034 Both channels, defaults: A=12'h800, B=12'h123, strobe.
  - Required: frames 16'h3800 then 16'hB123, each 64 cs_n-low cycles, 4-cycle gap between them.
  - Then 4-cycle gap, ldac_n low 2 cycles, done pulse.
  - Total busy=1 duration: 138 cycles.
REQ-035 Only enableB=1, B=12'hFFF: single frame 16'hBFFF, then gap, then LDAC, then done; no channel-A frame.
REQ-036 Second strobe 10 cycles after the first: overrun pulses once; the first transaction's frames are bit-identical to the no-overrun case.
REQ-037 rst_n=0 asserted at the 5th sck rising edge of frame A: outputs at reset values next edge, no ldac_n pulse; a later strobe produces a complete, correct transaction.
REQ-038 CLK_DIV=1, CS_GAP=1, LDAC_W=1: each frame has 32 cs_n-low cycles; sck period is 2 cycles; sdi is stable around every rising edge.
